// File: rtl/dma_chan_addr_engine_if.sv
// Bus bundle between the CPU register port / DMA timing FSM (master) and the
// channel address engine (slave).
interface dma_chan_addr_engine_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cpu_wr;
  logic              cpu_rd;
  logic [CH_W-1:0]   cpu_ch;
  logic              cpu_sel;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              clr_ff;
  logic [NUM_CH-1:0] dec_mode;
  logic [NUM_CH-1:0] auto_init;
  logic [CH_W-1:0]   act_ch;
  logic              start;
  logic              adv;
  logic              ext_eop_n;
  logic [ADDR_W-1:0] addr_out;
  logic              adstb;
  logic              busy;
  logic              tc;
  logic              eop_n;
  logic [NUM_CH-1:0] ch_done;

  modport master (
    output cpu_wr, cpu_rd, cpu_ch, cpu_sel, cpu_din, clr_ff, dec_mode, auto_init,
           act_ch, start, adv, ext_eop_n,
    input  cpu_dout, addr_out, adstb, busy, tc, eop_n, ch_done
  );

  modport slave (
    input  cpu_wr, cpu_rd, cpu_ch, cpu_sel, cpu_din, clr_ff, dec_mode, auto_init,
           act_ch, start, adv, ext_eop_n,
    output cpu_dout, addr_out, adstb, busy, tc, eop_n, ch_done
  );
endinterface

// File: rtl/dma_chan_addr_engine.sv
// Multi-channel DMA base/current address and word-count engine with TC/EOP detection.
// Optional auto-initialise on terminal count: define DMA_AUTOINIT_EN.
module dma_chan_addr_engine #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dma_chan_addr_engine_if.slave bus
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NCH_PAD = 1 << CH_W;
  localparam int NBA     = int'(ADDR_W) / 8;
  localparam int NBC     = int'(CNT_W) / 8;

  typedef enum logic [1:0] {StIdle, StLoad, StActive, StTerm} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_addr_q [NCH_PAD];
  logic [ADDR_W-1:0] cur_addr_q  [NCH_PAD];
  logic [CNT_W-1:0]  base_cnt_q  [NCH_PAD];
  logic [CNT_W-1:0]  cur_cnt_q   [NCH_PAD];
  logic [NCH_PAD-1:0] ch_done_q;

  logic [1:0]        ptr_q;
  logic [CH_W-1:0]   act_q;
  logic [7:0]        cpu_dout_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic              adstb_q, busy_q, tc_q, eop_n_q;

  logic [ADDR_W-1:0] cur_a, addr_nxt;
  logic [CNT_W-1:0]  cur_c;
  logic              adv_ok, tc_hit, upper_chg, ptr_last;

  assign cur_a     = cur_addr_q[act_q];
  assign cur_c     = cur_cnt_q[act_q];
  assign addr_nxt  = bus.dec_mode[act_q] ? cur_a - ADDR_W'(1) : cur_a + ADDR_W'(1);
  assign upper_chg = ((addr_nxt ^ cur_a) >> 8) != '0;
  // A CPU write to the serviced channel takes precedence over the transfer strobe.
  assign adv_ok    = (state_q == StActive) && bus.adv && !(bus.cpu_wr && bus.cpu_ch == act_q);
  assign tc_hit    = adv_ok && (cur_c == '0);
  assign ptr_last  = int'(ptr_q) >= ((bus.cpu_sel ? NBC : NBA) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StLoad;
      StLoad:   state_d = StActive;
      StActive: if (tc_hit || !bus.ext_eop_n) state_d = StTerm;
      StTerm:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH_PAD; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
      end
      ch_done_q  <= '0;
      ptr_q      <= '0;
      act_q      <= '0;
      cpu_dout_q <= '0;
      addr_out_q <= '0;
      adstb_q    <= 1'b0;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
      eop_n_q    <= 1'b1;
    end else begin
      adstb_q <= 1'b0;
      tc_q    <= 1'b0;
      eop_n_q <= 1'b1;
      busy_q  <= (state_d != StIdle);

      if (state_q == StIdle && bus.start) act_q <= bus.act_ch;

      if (state_q == StLoad) begin
        addr_out_q <= cur_a;
        adstb_q    <= 1'b1;
      end

      if (adv_ok) begin
        cur_addr_q[act_q] <= addr_nxt;
        cur_cnt_q[act_q]  <= cur_c - CNT_W'(1);
        addr_out_q        <= addr_nxt;
        adstb_q           <= upper_chg;
      end

      // Termination outputs are registered so they coincide with the TERM state.
      if (state_q == StActive && state_d == StTerm) begin
        tc_q             <= tc_hit;
        eop_n_q          <= 1'b0;
        ch_done_q[act_q] <= 1'b1;
      end

`ifdef DMA_AUTOINIT_EN
      if (state_q == StTerm && bus.auto_init[act_q]) begin
        cur_addr_q[act_q] <= base_addr_q[act_q];
        cur_cnt_q[act_q]  <= base_cnt_q[act_q];
      end
`endif

      if (bus.cpu_wr) begin
        for (int b = 0; b < NBA; b++) begin
          if (!bus.cpu_sel && int'(ptr_q) == b) begin
            base_addr_q[bus.cpu_ch][8*b +: 8] <= bus.cpu_din;
            cur_addr_q[bus.cpu_ch][8*b +: 8]  <= bus.cpu_din;
          end
        end
        for (int b = 0; b < NBC; b++) begin
          if (bus.cpu_sel && int'(ptr_q) == b) begin
            base_cnt_q[bus.cpu_ch][8*b +: 8] <= bus.cpu_din;
            cur_cnt_q[bus.cpu_ch][8*b +: 8]  <= bus.cpu_din;
          end
        end
        if (bus.cpu_sel) ch_done_q[bus.cpu_ch] <= 1'b0;
      end

      if (bus.cpu_rd) begin
        cpu_dout_q <= '0;
        for (int b = 0; b < NBA; b++) begin
          if (!bus.cpu_sel && int'(ptr_q) == b) cpu_dout_q <= cur_addr_q[bus.cpu_ch][8*b +: 8];
        end
        for (int b = 0; b < NBC; b++) begin
          if (bus.cpu_sel && int'(ptr_q) == b) cpu_dout_q <= cur_cnt_q[bus.cpu_ch][8*b +: 8];
        end
      end

      if (bus.clr_ff)                    ptr_q <= '0;
      else if (bus.cpu_wr || bus.cpu_rd) ptr_q <= ptr_last ? 2'd0 : ptr_q + 2'd1;
    end
  end

`ifndef DMA_AUTOINIT_EN
  // Base registers only feed auto-initialise; keep them visibly consumed.
  logic unused_base;
  always_comb begin
    unused_base = ^bus.auto_init;
    for (int i = 0; i < NCH_PAD; i++) begin
      unused_base = unused_base ^ (^base_addr_q[i]) ^ (^base_cnt_q[i]);
    end
  end
`endif

  assign bus.cpu_dout = cpu_dout_q;
  assign bus.addr_out = addr_out_q;
  assign bus.adstb    = adstb_q;
  assign bus.busy     = busy_q;
  assign bus.tc       = tc_q;
  assign bus.eop_n    = eop_n_q;
  assign bus.ch_done  = ch_done_q[NUM_CH-1:0];
endmodule

// File: tb/tb_dma_chan_addr_engine.sv
// Scoreboard bench for dma_chan_addr_engine: expected addresses and read bytes are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_dma_chan_addr_engine;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dma_chan_addr_engine_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) b ();

  dma_chan_addr_engine #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        stb;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  rd_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_addr;
  logic        m_dec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    b.clr_ff = 1'b1;
    step();
    b.clr_ff = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic sel, input logic [7:0] d);
    b.cpu_ch  = ch;
    b.cpu_sel = sel;
    b.cpu_din = d;
    b.cpu_wr  = 1'b1;
    step();
    b.cpu_wr  = 1'b0;
  endtask

  task automatic wr16(input logic [1:0] ch, input logic sel, input logic [15:0] v);
    clr();
    wr(ch, sel, v[7:0]);
    wr(ch, sel, v[15:8]);
  endtask

  task automatic rd(input string tag, input logic [1:0] ch, input logic sel,
                    input logic [7:0] exp);
    logic [7:0] e;
    rd_q.push_back(exp);
    b.cpu_ch  = ch;
    b.cpu_sel = sel;
    b.cpu_rd  = 1'b1;
    step();
    b.cpu_rd  = 1'b0;
    e = rd_q.pop_front();
    check_eq(tag, 32'(b.cpu_dout), 32'(e));
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    check_eq({tag, "_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_addr"}, 32'(b.addr_out), 32'(e.addr));
      check_eq({tag, "_stb"}, 32'(b.adstb), 32'(e.stb));
    end
  endtask

  task automatic start_xfer(input string tag, input logic [1:0] ch, input logic [15:0] a,
                            input logic dec);
    exp_t e;
    m_addr   = a;
    m_dec    = dec;
    b.act_ch = ch;
    b.start  = 1'b1;
    step();
    b.start  = 1'b0;
    check_eq({tag, "_busy"}, 32'(b.busy), 32'd1);
    e.addr = a;
    e.stb  = 1'b1;
    sb_q.push_back(e);
    step();
    pop_chk({tag, "_load"});
  endtask

  task automatic do_adv(input string tag);
    exp_t        e;
    logic [15:0] old;
    old    = m_addr;
    m_addr = m_dec ? m_addr - 16'd1 : m_addr + 16'd1;
    e.addr = m_addr;
    e.stb  = (old[15:8] != m_addr[15:8]);
    sb_q.push_back(e);
    b.adv = 1'b1;
    step();
    b.adv = 1'b0;
    pop_chk(tag);
  endtask

  task automatic chk_term(input string tag, input logic exp_tc);
    check_eq({tag, "_eop"}, 32'(b.eop_n), 32'd0);
    check_eq({tag, "_tc"}, 32'(b.tc), 32'(exp_tc));
    step();
    check_eq({tag, "_eop_end"}, 32'(b.eop_n), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(b.busy), 32'd0);
  endtask

  task automatic ext_eop();
    b.ext_eop_n = 1'b0;
    step();
    b.ext_eop_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    b.cpu_wr = 1'b0; b.cpu_rd = 1'b0; b.cpu_ch = '0; b.cpu_sel = 1'b0; b.cpu_din = '0;
    b.clr_ff = 1'b0; b.dec_mode = '0; b.auto_init = '0; b.act_ch = '0;
    b.start = 1'b0; b.adv = 1'b0; b.ext_eop_n = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    check_eq("rst_addr", 32'(b.addr_out), 32'h0);
    check_eq("rst_adstb", 32'(b.adstb), 32'd0);
    check_eq("rst_busy", 32'(b.busy), 32'd0);
    check_eq("rst_tc", 32'(b.tc), 32'd0);
    check_eq("rst_eop", 32'(b.eop_n), 32'd1);
    check_eq("rst_done", 32'(b.ch_done), 32'h0);
    check_eq("rst_dout", 32'(b.cpu_dout), 32'h0);

    // Byte pointer: clr_ff between writes restarts at the low byte.
    clr();
    wr(2'd3, 1'b0, 8'hAB);
    clr();
    wr(2'd3, 1'b0, 8'hCD);
    wr(2'd3, 1'b0, 8'hEF);
    rd("ff_lo", 2'd3, 1'b0, 8'hCD);
    rd("ff_hi", 2'd3, 1'b0, 8'hEF);

    // Channel 2 full count-to-TC transfer.
    wr16(2'd2, 1'b0, 16'h1234);
    wr16(2'd2, 1'b1, 16'h0002);
    start_xfer("c2", 2'd2, 16'h1234, 1'b0);
    do_adv("c2_adv1");
    do_adv("c2_adv2");
    do_adv("c2_adv3");
    chk_term("c2_term", 1'b1);
    check_eq("c2_done", 32'(b.ch_done), 32'h4);
    clr();
    rd("c2_cnt_lo", 2'd2, 1'b1, 8'hFF);
    rd("c2_cnt_hi", 2'd2, 1'b1, 8'hFF);
    rd("c2_cur_lo", 2'd2, 1'b0, 8'h37);

    // Channel 0: ADSTB only on LOAD and the 0x00FF -> 0x0100 carry.
    wr16(2'd0, 1'b0, 16'h00FF);
    wr16(2'd0, 1'b1, 16'h0005);
    start_xfer("c0", 2'd0, 16'h00FF, 1'b0);
    do_adv("c0_adv1");
    do_adv("c0_adv2");
    ext_eop();
    chk_term("c0_term", 1'b0);

    // Channel 1 decrement wrap, then external EOP.
    b.dec_mode = 4'b0010;
    wr16(2'd1, 1'b0, 16'h0000);
    wr16(2'd1, 1'b1, 16'h0009);
    start_xfer("c1", 2'd1, 16'h0000, 1'b1);
    do_adv("c1_adv1");
    ext_eop();
    check_eq("c1_hold_addr", 32'(b.addr_out), 32'hFFFF);
    chk_term("c1_term", 1'b0);
    check_eq("c1_done", 32'(b.ch_done), 32'h7);
    b.dec_mode = '0;

    // Reset in the middle of an active transfer.
    wr16(2'd1, 1'b0, 16'h1234);
    wr16(2'd1, 1'b1, 16'h0010);
    start_xfer("rm", 2'd1, 16'h1234, 1'b0);
    do_adv("rm_adv1");
    rst = 1'b1;
    step();
    check_eq("rm_addr", 32'(b.addr_out), 32'h0);
    check_eq("rm_busy", 32'(b.busy), 32'd0);
    check_eq("rm_eop", 32'(b.eop_n), 32'd1);
    check_eq("rm_done", 32'(b.ch_done), 32'h0);
    rst = 1'b0;
    step();
    check_eq("rm_eop2", 32'(b.eop_n), 32'd1);
    check_eq("rm_busy2", 32'(b.busy), 32'd0);
    rd("rm_cur_hi", 2'd1, 1'b0, 8'h00);

`ifdef DMA_AUTOINIT_EN
    b.auto_init = 4'b0001;
    wr16(2'd0, 1'b0, 16'h2000);
    wr16(2'd0, 1'b1, 16'h0001);
    start_xfer("ai", 2'd0, 16'h2000, 1'b0);
    do_adv("ai_adv1");
    do_adv("ai_adv2");
    chk_term("ai_term", 1'b1);
    check_eq("ai_done", 32'(b.ch_done), 32'h1);
    clr();
    rd("ai_addr_lo", 2'd0, 1'b0, 8'h00);
    rd("ai_addr_hi", 2'd0, 1'b0, 8'h20);
    rd("ai_cnt_lo", 2'd0, 1'b1, 8'h01);
    b.auto_init = '0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
